// File: rtl/sa_cache_ctrl.sv
// Tag-only set-associative cache controller with true-LRU replacement, refill handshake and saturating counters.
// Optional write-back/dirty tracking is enabled by defining WB_DIRTY_EN.
module sa_cache_ctrl #(
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 16,
  parameter int CACHE_BYTES = 32768,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16,
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wb,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  evict_count,
  output logic [CNT_W-1:0]  wb_count
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int SETS  = CACHE_BYTES / (BLOCK_BYTES * WAYS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, RESP} state_t;

  state_t                   state, state_nx;
  logic [ADDR_W-OFF_W-1:0]  blk_r;
  logic [IDX_W-1:0]         idx_r;
  logic [TAG_W-1:0]         tag_r;
  logic [WAY_W-1:0]         way_r;

  logic                     valid_q [SETS][WAYS];
  logic [TAG_W-1:0]         tag_q   [SETS][WAYS];
  logic [WAY_W-1:0]         age_q   [SETS][WAYS];

  logic                     hit, found_inv;
  logic [WAY_W-1:0]         hit_way, victim;
  logic                     upd_en;
  logic [WAY_W-1:0]         upd_way, upd_age;

  // Block offset is never stored; only block-aligned addresses leave the controller.
  logic unused_off;
  assign unused_off = ^req_addr[OFF_W-1:0];

`ifdef WB_DIRTY_EN
  logic write_r;
  logic wb_r;
  logic dirty_q [SETS][WAYS];
`else
  logic unused_write;
  assign unused_write = req_write;
  assign wb_count     = '0;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign idx_r = blk_r[IDX_W-1:0];
  assign tag_r = blk_r[ADDR_W-OFF_W-1:IDX_W];

  // Tag match and victim choice: lowest invalid way first, else the oldest way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx_r][w] && tag_q[idx_r][w] == tag_r) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found_inv && !valid_q[idx_r][w]) begin
        found_inv = 1'b1;
        victim    = WAY_W'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[idx_r][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  assign upd_en  = (state == LOOKUP && hit) || (state == FILL);
  assign upd_way = (state == FILL) ? way_r : hit_way;
  assign upd_age = age_q[idx_r][upd_way];

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = LOOKUP;
      end
      LOOKUP:   state_nx = hit ? RESP : MISS_REQ;
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_ack) state_nx = FILL;
      end
      FILL:     state_nx = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

`ifdef WB_DIRTY_EN
  assign mem_req_wb = wb_r && mem_req_valid;
`else
  assign mem_req_wb = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      blk_r        <= '0;
      way_r        <= '0;
      resp_hit     <= 1'b0;
      mem_req_addr <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      evict_count  <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
`ifdef WB_DIRTY_EN
          dirty_q[s][w] <= 1'b0;
`endif
        end
      end
`ifdef WB_DIRTY_EN
      write_r  <= 1'b0;
      wb_r     <= 1'b0;
      wb_count <= '0;
`endif
    end else begin
      state <= state_nx;
      // Ages younger than the touched way shift up by one; the touched way becomes youngest.
      if (upd_en) begin
        for (int v = 0; v < WAYS; v++) begin
          if (WAY_W'(v) == upd_way) age_q[idx_r][v] <= '0;
          else if (age_q[idx_r][v] < upd_age) age_q[idx_r][v] <= age_q[idx_r][v] + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            blk_r <= req_addr[ADDR_W-1:OFF_W];
`ifdef WB_DIRTY_EN
            write_r <= req_write;
`endif
          end
        end
        LOOKUP: begin
          resp_hit <= hit;
          if (hit) begin
            way_r     <= hit_way;
            hit_count <= sat_inc(hit_count);
`ifdef WB_DIRTY_EN
            if (write_r) dirty_q[idx_r][hit_way] <= 1'b1;
`endif
          end else begin
            way_r        <= victim;
            miss_count   <= sat_inc(miss_count);
            mem_req_addr <= {blk_r, {OFF_W{1'b0}}};
            if (!found_inv) evict_count <= sat_inc(evict_count);
`ifdef WB_DIRTY_EN
            wb_r <= !found_inv && dirty_q[idx_r][victim];
            if (!found_inv && dirty_q[idx_r][victim]) wb_count <= sat_inc(wb_count);
`endif
          end
        end
        FILL: begin
          valid_q[idx_r][way_r] <= 1'b1;
          tag_q[idx_r][way_r]   <= tag_r;
`ifdef WB_DIRTY_EN
          dirty_q[idx_r][way_r] <= write_r;
`endif
        end
        default: ;
      endcase
    end
  end

  assign resp_way = way_r;

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Directed-vector bench for sa_cache_ctrl (default geometry, CNT_W=4 so saturation is reachable).
module tb_sa_cache_ctrl;
  localparam int CNT_W = 4;
`ifdef WB_DIRTY_EN
  localparam logic WB_EXP = 1'b1;
`else
  localparam logic WB_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready, resp_valid, resp_hit, mem_req_valid, mem_req_wb;
  logic [1:0]  resp_way;
  logic [31:0] mem_req_addr;
  logic [CNT_W-1:0] hit_count, miss_count, evict_count, wb_count;

  sa_cache_ctrl #(
    .WAYS(4), .BLOCK_BYTES(16), .CACHE_BYTES(32768), .ADDR_W(32), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wb(mem_req_wb),
    .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count), .evict_count(evict_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  logic        r_hit, r_wb, r_busy;
  logic [1:0]  r_way;
  logic [31:0] r_maddr;
  int          r_lat;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One access; ack_dly = request cycles before mem_ack; hold keeps req_valid up until the response.
  task automatic access(input logic [31:0] addr, input logic wr, input int ack_dly, input logic hold);
    int cyc;
    int nreq;
    bit done;
    cyc = 0; nreq = 0; done = 0;
    r_hit = 0; r_way = 0; r_maddr = 0; r_wb = 0; r_busy = 0; r_lat = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1; req_addr = addr; req_write = wr;
    @(negedge clk);
    if (!hold) begin
      req_valid = 1'b0;
      req_write = 1'b0;
    end
    cyc = 1;
    r_busy = req_ready;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (resp_valid) begin
        r_hit = resp_hit; r_way = resp_way; r_lat = cyc; done = 1;
        req_valid = 1'b0; req_write = 1'b0;
      end else begin
        r_busy |= req_ready;
        if (mem_req_valid) begin
          r_maddr = mem_req_addr; r_wb = mem_req_wb;
          if (nreq == ack_dly) mem_ack = 1'b1;
          nreq++;
        end
      end
    end
    mem_ack = 1'b0;
    req_valid = 1'b0;
    if (!done) check("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] fill_addr [4];
    fill_addr[0] = 32'h0; fill_addr[1] = 32'h2000; fill_addr[2] = 32'h4000; fill_addr[3] = 32'h6000;

    do_reset();
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_way", resp_way, 0);
    check("rst_mreq_valid", mem_req_valid, 0);
    check("rst_mreq_addr", mem_req_addr, 0);
    check("rst_mreq_wb", mem_req_wb, 0);
    check("rst_counters", {hit_count, miss_count, evict_count, wb_count}, 0);

    // Cold miss with delayed ack, requester holding req_valid, then a hit in the same block.
    access(32'h1230, 1'b0, 3, 1'b1);
    check("cm_hit", r_hit, 0);
    check("cm_way", r_way, 0);
    check("cm_maddr", r_maddr, 32'h1230);
    check("cm_lat", r_lat, 7);
    check("cm_ready_busy", r_busy, 0);
    check("cm_miss_once", miss_count, 1);
    access(32'h1234, 1'b0, 0, 1'b0);
    check("h_hit", r_hit, 1);
    check("h_way", r_way, 0);
    check("h_lat", r_lat, 2);
    check("h_hit_count", hit_count, 1);
    check("h_miss_count", miss_count, 1);

    // Fill all four ways of set 0, re-touch way 0, then evict the LRU way.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      access(fill_addr[i], 1'b0, 0, 1'b0);
      check("lru_fill_way", r_way, i);
      check("lru_fill_hit", r_hit, 0);
    end
    access(32'h0, 1'b0, 0, 1'b0);
    check("lru_rehit", r_hit, 1);
    check("lru_rehit_way", r_way, 0);
    access(32'h8000, 1'b0, 1, 1'b0);
    check("lru_ev_hit", r_hit, 0);
    check("lru_ev_way", r_way, 1);
    check("lru_ev_addr", r_maddr, 32'h8000);
    check("lru_ev_count", evict_count, 1);
    access(32'h2000, 1'b0, 0, 1'b0);
    check("lru_ev2_hit", r_hit, 0);
    check("lru_ev2_way", r_way, 2);
    check("lru_ev2_count", evict_count, 2);
    check("lru_hits", hit_count, 1);
    check("lru_misses", miss_count, 6);

    // Dirty victim write-back.
    do_reset();
    access(32'h0, 1'b1, 0, 1'b0);
    access(32'h2000, 1'b0, 0, 1'b0);
    check("wb_clean_victim", r_wb, 0);
    access(32'h4000, 1'b0, 0, 1'b0);
    access(32'h6000, 1'b0, 0, 1'b0);
    access(32'h8000, 1'b0, 2, 1'b0);
    check("wb_req", r_wb, WB_EXP);
    check("wb_way", r_way, 0);
    check("wb_count", wb_count, WB_EXP);
    check("wb_evict", evict_count, 1);

    // Reset while a refill request is outstanding, with an ack straddling the reset.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h40; req_write = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rm_mreq", mem_req_valid, 1);
    check("rm_miss_pre", miss_count, 1);
    rst = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rm_mreq_off", mem_req_valid, 0);
    check("rm_ready", req_ready, 1);
    check("rm_miss_clr", miss_count, 0);
    @(negedge clk);
    check("rm_ack_ign", {mem_req_valid, resp_valid, req_ready}, 3'b001);
    mem_ack = 1'b0;
    access(32'h40, 1'b0, 0, 1'b0);
    check("rm_remiss", r_hit, 0);
    check("rm_miss_count", miss_count, 1);

    // Stray ack while idle.
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_state", {mem_req_valid, resp_valid, req_ready}, 3'b001);
    check("stray_counts", {hit_count, miss_count}, {4'd0, 4'd1});
    access(32'h40, 1'b0, 0, 1'b0);
    check("stray_then_hit", r_hit, 1);

    // Counter saturation.
    do_reset();
    access(32'h100, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      access(32'h104, 1'b0, 0, 1'b0);
      if (i == 14) check("sat_14", hit_count, 14);
    end
    check("sat_hit", hit_count, 15);
    check("sat_miss", miss_count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
